// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared reset address, instruction-memory bounds and state encoding
package pc_unit_pkg;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam int IM_WORDS = 4096;
  localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * IM_WORDS) - 32'd4;
  typedef enum logic {RUN, HALT} state_t;
endpackage

// File: rtl/pc_unit_npc_calc.sv
// pc_unit_npc_calc: next-fetch target mux (jr > jump > branch > sequential) and legality check
module pc_unit_npc_calc
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] P_PC_RESET = PC_RESET,
  parameter int P_IM_WORDS = IM_WORDS
) (
  input  logic [31:0] i_pc_plus4,
  input  logic        i_pc_source,
  input  logic [15:0] i_imm16,
  input  logic        i_jump,
  input  logic [25:0] i_instr_index,
  input  logic        i_jr,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_target,
  output logic        o_legal
);
  localparam logic [31:0] L_LAST = P_PC_RESET + 32'(4 * P_IM_WORDS) - 32'd4;
  logic [31:0] w_branch;
  assign w_branch = i_pc_plus4 + {{14{i_imm16[15]}}, i_imm16, 2'b00};
  assign o_target = i_jr ? i_jr_target :
                    i_jump ? {i_pc_plus4[31:28], i_instr_index, 2'b00} :
                    i_pc_source ? w_branch : i_pc_plus4;
  assign o_legal = (o_target[1:0] == 2'b00) && (o_target >= P_PC_RESET) && (o_target <= L_LAST);
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with stall hold, retired-instruction count and sticky fetch-fault halt
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] P_PC_RESET = PC_RESET,
  parameter int P_IM_WORDS = IM_WORDS
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_pc_source,
  input  logic [15:0] i_imm16,
  input  logic        i_jump,
  input  logic [25:0] i_instr_index,
  input  logic        i_jr,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_instr_count,
  output logic        o_halted,
  output logic [31:0] o_fault_pc,
  output logic [31:0] o_fault_target
);
  state_t      r_state;
  logic [31:0] r_pc, r_count, r_fault_pc, r_fault_target;
  logic        r_halted;
  logic [31:0] w_target;
  logic        w_legal;

  assign o_pc = r_pc;
  assign o_pc_plus4 = r_pc + 32'd4;
  assign o_instr_count = r_count;
  assign o_halted = r_halted;
  assign o_fault_pc = r_fault_pc;
  assign o_fault_target = r_fault_target;

  pc_unit_npc_calc #(.P_PC_RESET(P_PC_RESET), .P_IM_WORDS(P_IM_WORDS)) u_npc (
    .i_pc_plus4(o_pc_plus4),
    .i_pc_source(i_pc_source),
    .i_imm16(i_imm16),
    .i_jump(i_jump),
    .i_instr_index(i_instr_index),
    .i_jr(i_jr),
    .i_jr_target(i_jr_target),
    .o_target(w_target),
    .o_legal(w_legal)
  );

  // advance, retire and latch faults in RUN; HALT freezes everything until reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= RUN;
      r_pc <= P_PC_RESET;
      r_count <= '0;
      r_halted <= 1'b0;
      r_fault_pc <= '0;
      r_fault_target <= '0;
    end else if (r_state == RUN && !i_stall) begin
      r_count <= r_count + 32'd1;
      if (w_legal) begin
        r_pc <= w_target;
      end else begin
        r_state <= HALT;
        r_halted <= 1'b1;
        r_fault_pc <= r_pc;
        r_fault_target <= w_target;
      end
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        pc_source = 1'b0;
  logic [15:0] imm16 = '0;
  logic        jump = 1'b0;
  logic [25:0] instr_index = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic [31:0] pc, pc_plus4, instr_count, fault_pc, fault_target;
  logic        halted;
  int n_cmp = 0;
  int n_err = 0;

  pc_unit dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_stall(stall),
    .i_pc_source(pc_source),
    .i_imm16(imm16),
    .i_jump(jump),
    .i_instr_index(instr_index),
    .i_jr(jr),
    .i_jr_target(jr_target),
    .o_pc(pc),
    .o_pc_plus4(pc_plus4),
    .o_instr_count(instr_count),
    .o_halted(halted),
    .o_fault_pc(fault_pc),
    .o_fault_target(fault_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_run(input string tag, input logic [31:0] e_pc, input logic [31:0] e_cnt, input logic e_halt);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".cnt"}, instr_count, e_cnt);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halt});
  endtask

  task automatic chk_fault(input string tag, input logic [31:0] e_fpc, input logic [31:0] e_ftgt);
    chk({tag, ".fault_pc"}, fault_pc, e_fpc);
    chk({tag, ".fault_target"}, fault_target, e_ftgt);
  endtask

  task automatic drive(input logic s, input logic ps, input logic [15:0] imm, input logic j,
                       input logic [25:0] idx, input logic r, input logic [31:0] tgt);
    stall = s; pc_source = ps; imm16 = imm; jump = j; instr_index = idx; jr = r; jr_target = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk_run("reset", 32'h3000, 0, 1'b0);
    chk_fault("reset", 0, 0);
    chk("reset.pc_plus4", pc_plus4, 32'h3004);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step(); chk_run("seq1", 32'h3004, 1, 1'b0);
    step(); chk_run("seq2", 32'h3008, 2, 1'b0);
    step(); chk_run("seq3", 32'h300C, 3, 1'b0);
    chk("seq3.pc_plus4", pc_plus4, 32'h3010);
    drive(1, 1, 16'hFFFE, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(); chk_run("stall", 32'h300C, 3, 1'b0);
    end
    stall = 1'b0;
    step(); chk_run("stall_release_branch", 32'h3008, 4, 1'b0);
    step(); chk_run("branch_back", 32'h3004, 5, 1'b0);
    imm16 = 16'h0003;
    step(); chk_run("branch_fwd", 32'h3014, 6, 1'b0);
    drive(0, 0, 0, 1, 26'h0000C05, 0, 0);
    step(); chk_run("jump", 32'h3014, 7, 1'b0);
    drive(0, 0, 0, 1, 26'h0000C05, 1, 32'h3020);
    step(); chk_run("jr_over_jump", 32'h3020, 8, 1'b0);
    drive(0, 0, 0, 0, 0, 1, 32'h6FFC);
    step(); chk_run("jr_top", 32'h6FFC, 9, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step(); chk_run("run_off_top", 32'h6FFC, 10, 1'b1);
    chk_fault("run_off_top", 32'h6FFC, 32'h7000);
    #3 reset = 1'b1;
    #1 chk_run("async_reset", 32'h3000, 0, 1'b0);
    chk_fault("async_reset", 0, 0);
    #1 reset = 1'b0;
    #1 chk_run("async_reset_hold", 32'h3000, 0, 1'b0);
    drive(0, 1, 16'h8000, 0, 0, 1, 32'h3020);
    step(); chk_run("jr_over_branch", 32'h3020, 1, 1'b0);
    drive(0, 0, 0, 0, 0, 1, 32'h3018);
    step(); chk_run("jr_3018", 32'h3018, 2, 1'b0);
    jr_target = 32'h3002;
    step(); chk_run("jr_misaligned", 32'h3018, 3, 1'b1);
    chk_fault("jr_misaligned", 32'h3018, 32'h3002);
    for (int i = 0; i < 5; i++) begin
      drive(i[0], 1, 16'h0001, i[1], 26'h0000C10, i[0], 32'h3040);
      step(); chk_run("halt_hold", 32'h3018, 3, 1'b1);
      chk_fault("halt_hold", 32'h3018, 32'h3002);
    end
    reset = 1'b1;
    #1 chk_run("reset2", 32'h3000, 0, 1'b0);
    reset = 1'b0;
    drive(1, 1, 16'hFFF0, 0, 0, 0, 0);
    step(); chk_run("stall_illegal1", 32'h3000, 0, 1'b0);
    step(); chk_run("stall_illegal2", 32'h3000, 0, 1'b0);
    chk_fault("stall_illegal", 0, 0);
    stall = 1'b0;
    step(); chk_run("branch_below", 32'h3000, 1, 1'b1);
    chk_fault("branch_below", 32'h3000, 32'h2FC4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
